// File: rtl/patternbuf_loader.sv
// Serial load/readback controller for the pattern buffer: streams host bytes
// into the buffer's shift port, returns the displaced contents, and gates PAT writes.
module patternbuf_loader #(
  parameter int buffer_size  = 22,
  parameter int buffer_width = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    load_abort,
  input  logic                    load_valid,
  input  logic [buffer_width-1:0] load_data,
  output logic                    load_ready,
  output logic                    rb_valid,
  output logic [buffer_width-1:0] rb_data,
  output logic                    ssel,
  output logic                    sin,
  input  logic                    sout,
  input  logic                    pat_field_write,
  output logic                    field_write,
  output logic                    pat_write_stall,
  output logic                    busy,
  output logic                    done
);

  localparam int byte_cnt_w = $clog2(buffer_size);
  localparam int bit_cnt_w  = $clog2(buffer_width);
  localparam logic [byte_cnt_w-1:0] last_byte = byte_cnt_w'(buffer_size - 1);
  localparam logic [bit_cnt_w-1:0]  last_bit  = bit_cnt_w'(buffer_width - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BYTE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [byte_cnt_w-1:0]   byte_cnt_q, byte_cnt_d;
  logic [bit_cnt_w-1:0]    bit_cnt_q, bit_cnt_d;
  logic [buffer_width-1:0] tx_sr_q, tx_sr_d;
  // Only the first width-1 captured bits need storage; the last bit comes
  // straight from sout on the final shift edge.
  logic [buffer_width-2:0] rx_sr_q, rx_sr_d;
  logic [buffer_width-1:0] rx_shift;
  logic [buffer_width-1:0] rb_data_q, rb_data_d;
  logic                    rb_valid_q, rb_valid_d;

  assign rx_shift = {rx_sr_q, sout};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  // NOTE: every next-state signal gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;

    if (load_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            state_d    = ST_WAIT_BYTE;
            byte_cnt_d = '0;
          end
        end
        ST_WAIT_BYTE: begin
          if (load_valid) begin
            tx_sr_d   = load_data;
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          tx_sr_d = {tx_sr_q[buffer_width-2:0], 1'b0};
          rx_sr_d = rx_shift[buffer_width-2:0];
          if (bit_cnt_q == last_bit) begin
            rb_data_d  = rx_shift;
            rb_valid_d = 1'b1;
            byte_cnt_d = byte_cnt_q + byte_cnt_w'(1);
            state_d    = (byte_cnt_q == last_byte) ? ST_DONE : ST_WAIT_BYTE;
          end else begin
            bit_cnt_d = bit_cnt_q + bit_cnt_w'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign load_ready      = (state_q == ST_WAIT_BYTE);
  assign ssel            = (state_q == ST_SHIFT);
  assign sin             = ssel & tx_sr_q[buffer_width-1];
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign rb_valid        = rb_valid_q;
  assign rb_data         = rb_data_q;
  // Parallel writes only reach the buffer while no shift can be in flight.
  assign field_write     = pat_field_write & ~busy & ~reset;
  assign pat_write_stall = pat_field_write & busy;

endmodule

// File: tb/tb_patternbuf_loader.sv
// Bench for patternbuf_loader: a behavioural pattern buffer on the serial/parallel
// ports, a directed host driver, and a scoreboard monitor on the readback stream.
module tb_patternbuf_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start, load_abort, load_valid;
  logic [7:0] load_data;
  logic       load_ready, rb_valid;
  logic [7:0] rb_data;
  logic       ssel, sin, sout;
  logic       pat_field_write, field_write, pat_write_stall, busy, done;

  logic [4:0] fieldwp;
  logic [7:0] pat_data;
  logic [7:0] pbuf [22];
  logic [7:0] exp_field [22];
  logic [7:0] host_bytes [22];
  logic [7:0] sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int ssel_cnt = 0, done_cnt = 0, done_cyc = 0, rb_cnt = 0;
  int gap_cycles = 0, gap_bad = 0, rb_phase_bad = 0, arb_bad = 0;
  bit arb_mon = 1'b0;
  int mon_rel;
  logic [7:0] mon_exp;

  patternbuf_loader #(.buffer_size(22), .buffer_width(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .load_start      (load_start),
    .load_abort      (load_abort),
    .load_valid      (load_valid),
    .load_data       (load_data),
    .load_ready      (load_ready),
    .rb_valid        (rb_valid),
    .rb_data         (rb_data),
    .ssel            (ssel),
    .sin             (sin),
    .sout            (sout),
    .pat_field_write (pat_field_write),
    .field_write     (field_write),
    .pat_write_stall (pat_write_stall),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pattern buffer: field 0 LSB takes sin, field 21 MSB drives sout.
  assign sout = pbuf[21][7];
  always @(posedge clk) begin
    if (ssel) begin
      for (int i = 21; i > 0; i--) pbuf[i] <= {pbuf[i][6:0], pbuf[i-1][7]};
      pbuf[0] <= {pbuf[0][6:0], sin};
    end
    if (field_write) pbuf[fieldwp] <= pat_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    mon_rel = cyc - t0;
    if (ssel) ssel_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (load_ready && !load_valid) begin
      gap_cycles++;
      if (ssel) gap_bad++;
    end
    if (rb_valid) begin
      rb_cnt++;
      if (!(load_ready || done)) rb_phase_bad++;
      if (sb_q.size() == 0) check("rb_unexpected", 1, 0);
      else begin
        mon_exp = sb_q.pop_front();
        check("rb_data", {24'h0, rb_data}, {24'h0, mon_exp});
      end
    end
    if (arb_mon) begin
      if (mon_rel == 0) check("arb_same_cycle_write", {31'h0, field_write}, 1);
      else if (mon_rel <= 199) begin
        if (field_write !== 1'b0 || pat_write_stall !== 1'b1) arb_bad++;
      end else if (mon_rel == 200) begin
        check("arb_write_after_done", {31'h0, field_write}, 1);
        check("arb_no_stall_idle", {31'h0, pat_write_stall}, 0);
      end
    end
  end

  task automatic preload(input logic [7:0] base);
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      pat_field_write = 1'b1;
      fieldwp = 5'(i);
      pat_data = base + 8'(i);
    end
    @(posedge clk); #1;
    pat_field_write = 1'b0;
  endtask

  task automatic host_count_down();
    for (int k = 0; k < 22; k++) host_bytes[k] = 8'(21 - k);
  endtask

  task automatic host_const(input logic [7:0] v);
    for (int k = 0; k < 22; k++) host_bytes[k] = v;
  endtask

  task automatic push_rb(input logic [7:0] top, input int n);
    for (int k = 0; k < n; k++) sb_q.push_back(top - 8'(k));
  endtask

  task automatic check_fields(input string tag);
    for (int i = 0; i < 22; i++)
      check($sformatf("%s_field%0d", tag, i), {24'h0, pbuf[i]}, {24'h0, exp_field[i]});
  endtask

  // Drives one load from cycle 0 (load_start) and returns at the first cycle
  // the controller is idle again; stop_rel > 0 injects abort/reset at that cycle.
  task automatic run_load(input int gap_len, input int stop_rel, input bit use_reset,
                          input bit poke, input bit arb, output int end_rel);
    int idx;
    int gap_left;
    bit hs;
    bit ended;
    idx = 0; gap_left = gap_len; ended = 1'b0; end_rel = -1;
    @(posedge clk); #1;
    t0 = cyc;
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = host_bytes[0];
    if (arb) begin
      pat_field_write = 1'b1;
      fieldwp = 5'd3;
      pat_data = 8'h5A;
      arb_mon = 1'b1;
    end
    for (int r = 1; r < 400; r++) begin
      hs = load_valid && load_ready;
      @(posedge clk); #1;
      load_start = 1'b0;
      if (hs && idx < 21) idx++;
      load_data = host_bytes[idx];
      if (gap_left > 0 && idx == 7 && load_ready) begin
        load_valid = 1'b0;
        gap_left--;
      end else load_valid = 1'b1;
      if (arb && r == 1) check("arb_write_landed", {24'h0, pbuf[3]}, 32'h5A);
      if (poke && r == 20) load_start = 1'b1;
      if (r == stop_rel) begin
        if (use_reset) reset = 1'b1;
        else load_abort = 1'b1;
      end
      if (!busy) begin
        end_rel = r;
        ended = 1'b1;
        break;
      end
    end
    load_valid = 1'b0;
    check("load_terminated", {31'h0, ended}, 1);
  endtask

  task automatic full_load(input string tag, input int gap_len, input bit poke,
                           input bit arb, input int exp_done_rel);
    int s_ssel, s_done, s_rb, s_gap, s_gapbad, s_phase, end_rel;
    s_ssel = ssel_cnt; s_done = done_cnt; s_rb = rb_cnt;
    s_gap = gap_cycles; s_gapbad = gap_bad; s_phase = rb_phase_bad;
    run_load(gap_len, 0, 1'b0, poke, arb, end_rel);
    check({tag, "_ssel_cycles"}, ssel_cnt - s_ssel, 176);
    check({tag, "_done_pulses"}, done_cnt - s_done, 1);
    check({tag, "_done_cycle"}, done_cyc - t0, exp_done_rel);
    check({tag, "_idle_cycle"}, end_rel, exp_done_rel + 1);
    check({tag, "_rb_pulses"}, rb_cnt - s_rb, 22);
    check({tag, "_rb_phase"}, rb_phase_bad - s_phase, 0);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
    check({tag, "_gap_cycles"}, gap_cycles - s_gap, gap_len);
    check({tag, "_gap_ssel"}, gap_bad - s_gapbad, 0);
  endtask

  initial begin
    int s_done, s_rb, end_rel;
    reset = 1'b1;
    load_start = 1'b0; load_abort = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    pat_field_write = 1'b0; fieldwp = 5'd0; pat_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {23'h0, load_ready, rb_valid, ssel, sin, field_write,
                            pat_write_stall, busy, done, |rb_data}, 0);
    reset = 1'b0;

    // Full load of 0x15..0x00; old contents 0xC0+i come back field 21 first.
    preload(8'hC0);
    host_count_down();
    push_rb(8'hD5, 22);
    full_load("full", 0, 1'b0, 1'b0, 199);
    for (int i = 0; i < 22; i++) exp_field[i] = 8'(i);
    check_fields("full");

    // Readback of 0xA0+i while loading 0xFF.
    preload(8'hA0);
    host_const(8'hFF);
    push_rb(8'hB5, 22);
    full_load("readback", 0, 1'b0, 1'b0, 199);
    for (int i = 0; i < 22; i++) exp_field[i] = 8'hFF;
    check_fields("readback");

    // PAT write held on field 3 for the whole load; buffer is all 0xFF.
    host_count_down();
    for (int k = 0; k < 22; k++) sb_q.push_back((k == 18) ? 8'h5A : 8'hFF);
    s_done = arb_bad;
    full_load("arb", 0, 1'b0, 1'b1, 199);
    @(posedge clk); #1;
    pat_field_write = 1'b0;
    arb_mon = 1'b0;
    check("arb_stall_window", arb_bad - s_done, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) exp_field[i] = (i == 3) ? 8'h5A : 8'(i);
    check_fields("arb");

    // Host backpressure: five idle cycles before byte 7.
    preload(8'hA0);
    host_count_down();
    push_rb(8'hB5, 22);
    full_load("backpressure", 5, 1'b0, 1'b0, 204);
    for (int i = 0; i < 22; i++) exp_field[i] = 8'(i);
    check_fields("backpressure");

    // Abort on the 3rd shift of byte 4 (cycle 40).
    preload(8'hA0);
    host_const(8'hFF);
    push_rb(8'hB5, 4);
    s_done = done_cnt; s_rb = rb_cnt;
    run_load(0, 40, 1'b0, 1'b0, 1'b0, end_rel);
    check("abort_idle_cycle", end_rel, 41);
    check("abort_outputs", {28'h0, busy, ssel, load_ready, done}, 0);
    load_abort = 1'b0;
    @(posedge clk); #1;
    check("abort_done_pulses", done_cnt - s_done, 0);
    check("abort_rb_pulses", rb_cnt - s_rb, 4);
    check("abort_sb_empty", sb_q.size(), 0);

    preload(8'hA0);
    host_count_down();
    push_rb(8'hB5, 22);
    full_load("after_abort", 0, 1'b0, 1'b0, 199);
    for (int i = 0; i < 22; i++) exp_field[i] = 8'(i);
    check_fields("after_abort");

    // Same interruption with a synchronous reset.
    preload(8'hA0);
    host_const(8'hFF);
    push_rb(8'hB5, 4);
    s_done = done_cnt; s_rb = rb_cnt;
    run_load(0, 40, 1'b1, 1'b0, 1'b0, end_rel);
    check("reset_idle_cycle", end_rel, 41);
    check("reset_mid_outputs", {23'h0, load_ready, rb_valid, ssel, sin, field_write,
                                pat_write_stall, busy, done, |rb_data}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_done_pulses", done_cnt - s_done, 0);
    check("reset_rb_pulses", rb_cnt - s_rb, 4);
    check("reset_sb_empty", sb_q.size(), 0);

    // load_start pulsed mid-SHIFT and load_valid high in SHIFT are ignored.
    preload(8'hA0);
    host_count_down();
    push_rb(8'hB5, 22);
    full_load("ignored", 0, 1'b1, 1'b0, 199);
    for (int i = 0; i < 22; i++) exp_field[i] = 8'(i);
    check_fields("ignored");
    repeat (3) @(posedge clk);
    #1;
    check("ignored_no_restart", {31'h0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/patternbuf_loader.md
# patternbuf_loader

Serial load/readback controller for the pattern buffer. It accepts pattern bytes from the host front end over a valid/ready handshake and drives the buffer's `ssel`/`sin` shift port, 8 cycles per byte. While shifting it captures the old contents from `sout` and returns them as readback bytes. It also arbitrates the buffer's parallel write port: PAT field writes are passed through only while no load is in progress, so serial shifting and `field_write` are never active together.

## Interface

Parameters:
- `buffer_size`, 22, number of pattern fields (bytes) in the buffer
- `buffer_width`, 8, bits per field

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `load_start`  in  1  one-cycle request to begin a full-buffer load; sampled only in IDLE
- `load_abort`  in  1  return to IDLE from any state
- `load_valid`  in  1  host byte valid
- `load_data`  in  `buffer_width`  host byte
- `load_ready`  out  1  controller can accept a byte
- `rb_valid`  out  1  one-cycle pulse, `rb_data` valid
- `rb_data`  out  `buffer_width`  readback byte, i.e. the previous buffer contents
- `ssel`  out  1  to the buffer's serial select
- `sin`  out  1  to the buffer's serial input
- `sout`  in  1  from the buffer's serial output (MSB of the last field)
- `pat_field_write`  in  1  PAT write request
- `field_write`  out  1  gated write strobe to the buffer
- `pat_write_stall`  out  1  PAT write refused this cycle
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse on completion of a full load

## Operation

- FSM states: IDLE, WAIT_BYTE, SHIFT, DONE.
- **IDLE**
  - `load_start` moves to WAIT_BYTE and clears `byte_cnt`.
  - `field_write` = `pat_field_write`.
  - `pat_write_stall` = 0.
- **WAIT_BYTE**
  - `load_ready` = 1.
  - On `load_valid`: `tx_sr` is loaded with `load_data`, `bit_cnt` is cleared, and the FSM moves to SHIFT.
  - No timeout; the FSM waits indefinitely.
- **SHIFT**
  - `ssel` = 1, `sin` = `tx_sr[buffer_width-1]`.
  - Each cycle: `tx_sr` shifts left; `rx_sr` <= {`rx_sr`[buffer_width-2:0], `sout`}; `bit_cnt`++.
  - After `buffer_width` cycles:
    - `rb_data` <= final `rx_sr` value, `rb_valid` pulses next cycle.
    - `byte_cnt`++.
    - Next state is DONE if `byte_cnt` was `buffer_size`-1, otherwise WAIT_BYTE.
- **DONE**
  - `done` = 1 for one cycle, then the FSM moves to IDLE.
- **Byte order**
  - The host sends field `buffer_size`-1 first, field 0 last, each MSB first.
  - Readback bytes emerge in the same order (old field `buffer_size`-1 first), MSB-first reassembly.
- **PAT write arbitration**
  - In any state other than IDLE: `field_write` = 0 and `pat_write_stall` = `pat_field_write`.
  - Stalled writes are dropped, not queued; PAT must retry.
- **`ssel` and `sin` generation**
  - Both are decoded directly from registered state/`tx_sr`.
  - `ssel` is 0 in every state except SHIFT.
- **Boundary conditions**
  - `load_start` while `busy`: ignored.
  - `load_start` and `pat_field_write` in the same IDLE cycle: the write passes that cycle and the load starts next cycle.
  - `load_abort`: beats `load_valid` and all transitions, and IDLE is entered next cycle. Partial shifts remain in the buffer. No `done` or `rb_valid` is generated for the partial byte.
  - `load_valid` outside WAIT_BYTE: ignored, because `load_ready` = 0.
  - Counters: `byte_cnt` is `$clog2(buffer_size)` bits, `bit_cnt` is `$clog2(buffer_width)` bits. Neither wraps within a load; both are cleared on entry as specified.

## Timing

- **Reset** (synchronous): state IDLE, all counters and shift registers 0.
  - `load_ready`, `rb_valid`, `rb_data`, `ssel`, `sin`, `field_write`, `pat_write_stall`, `busy`, `done` are all 0.
  - Reset mid-load abandons the load with the buffer partially shifted.
- **Per-byte cost**: 1 handshake cycle + `buffer_width` shift cycles = 9 cycles with the default width and `load_valid` held high.
- **Full-load schedule** (defaults, `load_start` sampled at cycle 0, `load_valid` always high):
  - WAIT_BYTE at cycle 1.
  - Byte k shifts on cycles 2+9k..9+9k.
  - `done` and the final `rb_valid` at cycle 199.
  - IDLE at cycle 200.
- **Readback sampling**: `sout` is sampled on the same edge where the buffer shifts, so it captures the pre-shift bit.
- **`rb_valid`** is asserted in the cycle after the last shift of each byte, coincident with WAIT_BYTE or DONE.
- **`field_write`** is combinational from `pat_field_write` and state, with zero added latency.

## Test plan

- **Full load:** reset, then pulse `load_start` and stream bytes 0x15..0x00 (field 21 first) with `load_valid` high. Required:
  - `ssel` high for exactly 176 cycles.
  - `done` at cycle 199.
  - Buffer field i == i afterwards.
- **Readback:** preload the buffer with field i = 0xA0+i, then run a full load of 0xFF bytes. Required:
  - 22 `rb_valid` pulses with `rb_data` = 0xB5, 0xB4 … 0xA0.
  - Every field reads 0xFF afterwards.
- **Write arbitration:** hold `pat_field_write` = 1 with `fieldwp` = field 3 throughout a load. Required:
  - `field_write` = 0 and `pat_write_stall` = 1 from cycle 1 to cycle 199.
  - `field_write` = 1 at cycle 200.
  - Same-cycle `load_start` + write in IDLE: the write lands.
- **Host backpressure:** drop `load_valid` for 5 cycles before byte 7. Required:
  - `ssel` = 0 and `load_ready` = 1 for those cycles.
  - `done` is delayed by exactly 5 cycles (cycle 204).
  - Data is correct.
- **Abort and reset:**
  - Assert `load_abort` on the 3rd shift of byte 4. Required: IDLE next cycle, `busy` = 0, no `done`, only 4 `rb_valid` pulses; a new `load_start` then completes normally.
  - Repeat with `reset` instead of `load_abort`. Required: all outputs 0 on the following cycle.
- **Ignored requests:** pulse `load_start` during SHIFT and assert `load_valid` in SHIFT. Required: no restart, no extra byte accepted, `byte_cnt` unaffected.
